// File: rtl/safe_div_pkg.sv
// Shared definitions for the fixed-point divider: FSM state encoding,
// derived iteration-count helpers and saturation constants (also used by
// the fixed-point multiplier).
package safe_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Alignment shift applied to the numerator so the integer quotient lands
  // directly on the Q_FRAC binary point.
  function automatic int calc_shift(input int n_frac, input int d_frac, input int q_frac);
    return q_frac + d_frac - n_frac;
  endfunction

  // Number of restoring iterations: one per dividend bit.
  function automatic int calc_div_w(input int n_width, input int shift);
    return n_width + shift;
  endfunction

  // Largest positive two's-complement value of the given width.
  function automatic logic signed [63:0] sat_max(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  // Most negative two's-complement value of the given width.
  function automatic logic signed [63:0] sat_min(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/safe_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract |D| when it fits.
module safe_div_step #(
  parameter int D_WIDTH = 16
) (
  input  logic [D_WIDTH:0]   rem_in,
  input  logic               next_bit,
  input  logic [D_WIDTH-1:0] d_mag,
  output logic [D_WIDTH:0]   rem_out,
  output logic               q_bit
);

  logic [D_WIDTH+1:0] shifted;
  logic [D_WIDTH+1:0] d_ext;
  logic [D_WIDTH+1:0] diff;

  // Compare/subtract; the restored remainder is always below |D| so the
  // extra guard bit of the shifted value is never needed in the result.
  always_comb begin
    shifted = {rem_in, next_bit};
    d_ext   = (D_WIDTH + 2)'(d_mag);
    diff    = shifted - d_ext;
    q_bit   = (shifted >= d_ext);
    rem_out = q_bit ? (D_WIDTH + 1)'(diff) : (D_WIDTH + 1)'(shifted);
  end

endmodule

// File: rtl/safe_div.sv
// Sequential signed fixed-point divider, one quotient bit per clock.
// Sign-magnitude restoring algorithm; quotient truncates toward zero and is
// flagged on overflow or divide-by-zero.
// Optional build macro SAFE_DIV_SATURATE_EN clamps q on overflow (and on
// divide-by-zero, following the numerator sign) instead of wrapping.
module safe_div
  import safe_div_pkg::*;
#(
  parameter int N_WIDTH = 16,
  parameter int N_FRAC  = 14,
  parameter int D_WIDTH = 16,
  parameter int D_FRAC  = 14,
  parameter int Q_WIDTH = 16,
  parameter int Q_FRAC  = 14
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [N_WIDTH-1:0] n_in,
  input  logic signed [D_WIDTH-1:0] d_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [Q_WIDTH-1:0] q,
  output logic                      overflow,
  output logic                      div_by_zero
);

  localparam int SHIFT = calc_shift(N_FRAC, D_FRAC, Q_FRAC);
  localparam int DIV_W = calc_div_w(N_WIDTH, SHIFT);
  localparam int CNT_W = (DIV_W > 1) ? $clog2(DIV_W) : 1;
  // Wide enough to hold the magnitude and both overflow limits unsigned.
  localparam int CMP_W = ((DIV_W > Q_WIDTH) ? DIV_W : Q_WIDTH) + 1;

`ifdef SAFE_DIV_SATURATE_EN
  localparam logic [Q_WIDTH-1:0] Q_MAX = Q_WIDTH'(sat_max(Q_WIDTH));
  localparam logic [Q_WIDTH-1:0] Q_MIN = Q_WIDTH'(sat_min(Q_WIDTH));
`endif

  generate
    if (SHIFT < 0) begin : g_shift_check
      $error("safe_div: Q_FRAC + D_FRAC - N_FRAC must not be negative");
    end
  endgenerate

  div_state_t                state;
  div_state_t                state_nxt;
  logic [CNT_W-1:0]          cnt;
  logic [DIV_W-1:0]          dvd;
  logic [D_WIDTH-1:0]        d_mag;
  logic [D_WIDTH:0]          rem;
  logic [DIV_W-1:0]          m_reg;
  logic                      sign;
  logic signed [Q_WIDTH-1:0] q_r;
  logic                      ovf_r;
  logic                      dbz_r;

  logic [N_WIDTH-1:0]        n_abs;
  logic [D_WIDTH-1:0]        d_abs;
  logic [D_WIDTH:0]          step_rem;
  logic                      step_bit;
  logic [DIV_W-1:0]          m_next;
  logic                      accept;

  // Turn the final magnitude and sign into {overflow, q}; wraps by
  // truncation unless the saturating build is selected.
  function automatic logic [Q_WIDTH:0] pack_result(input logic [DIV_W-1:0] mag,
                                                   input logic             neg);
    logic [CMP_W-1:0]   mag_ext;
    logic [CMP_W-1:0]   lim;
    logic               ovf;
    logic [Q_WIDTH-1:0] qv;
    mag_ext = CMP_W'(mag);
    lim     = neg ? (CMP_W'(1) << (Q_WIDTH - 1))
                  : ((CMP_W'(1) << (Q_WIDTH - 1)) - CMP_W'(1));
    ovf     = (mag_ext > lim);
    qv      = neg ? Q_WIDTH'(~mag_ext + CMP_W'(1)) : Q_WIDTH'(mag_ext);
`ifdef SAFE_DIV_SATURATE_EN
    if (ovf) begin
      qv = neg ? Q_MIN : Q_MAX;
    end
`endif
    return {ovf, qv};
  endfunction

  assign n_abs  = n_in[N_WIDTH-1] ? (~$unsigned(n_in) + N_WIDTH'(1)) : $unsigned(n_in);
  assign d_abs  = d_in[D_WIDTH-1] ? (~$unsigned(d_in) + D_WIDTH'(1)) : $unsigned(d_in);
  assign accept = in_valid && in_ready;
  assign m_next = DIV_W'({m_reg, step_bit});

  safe_div_step #(
    .D_WIDTH (D_WIDTH)
  ) u_step (
    .rem_in   (rem),
    .next_bit (dvd[DIV_W-1]),
    .d_mag    (d_mag),
    .rem_out  (step_rem),
    .q_bit    (step_bit)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs; DONE never accepts in the same cycle.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = (d_in == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt == '0) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      dvd   <= '0;
      d_mag <= '0;
      rem   <= '0;
      m_reg <= '0;
      sign  <= 1'b0;
      q_r   <= '0;
      ovf_r <= 1'b0;
      dbz_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            dvd   <= DIV_W'(n_abs) << SHIFT;
            d_mag <= d_abs;
            sign  <= n_in[N_WIDTH-1] ^ d_in[D_WIDTH-1];
            rem   <= '0;
            m_reg <= '0;
            cnt   <= CNT_W'(DIV_W - 1);
            if (d_in == '0) begin
              ovf_r <= 1'b1;
              dbz_r <= 1'b1;
`ifdef SAFE_DIV_SATURATE_EN
              q_r   <= n_in[N_WIDTH-1] ? $signed(Q_MIN) : $signed(Q_MAX);
`else
              q_r   <= '0;
`endif
            end else begin
              ovf_r <= 1'b0;
              dbz_r <= 1'b0;
              q_r   <= '0;
            end
          end
        end
        CALC: begin
          dvd   <= dvd << 1;
          rem   <= step_rem;
          m_reg <= m_next;
          if (cnt == '0) begin
            {ovf_r, q_r} <= pack_result(m_next, sign);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign q           = q_r;
  assign overflow    = ovf_r;
  assign div_by_zero = dbz_r;

endmodule
